// File: rtl/main_fifo_pkg.sv
// Shared NoC definitions for the main input FIFO:
// word/pointer sizes, VC select bit and the VC pause helper.
package main_fifo_pkg;

    localparam int MF_DATA_SIZE = 6;
    localparam int MF_ADDR_SIZE = 2;
    localparam int MF_DEPTH     = 1 << MF_ADDR_SIZE;
    localparam int MF_VC_BIT    = MF_DATA_SIZE - 1;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_sel_e;

    // True when the VC the word is routed to cannot take it.
    function automatic logic vc_paused(
        input vc_sel_e sel,
        input logic    p0,
        input logic    p1
    );
        return (sel == VC1) ? p1 : p0;
    endfunction

endpackage

// File: rtl/main_fifo_mem.sv
// Register-array storage for the main FIFO:
// one synchronous write port, one asynchronous read port.
import main_fifo_pkg::*;

module main_fifo_mem #(
    parameter int DATA_SIZE = MF_DATA_SIZE,
    parameter int ADDR_SIZE = MF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    // Write port; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/main_fifo.sv
// Main input FIFO feeding the VC demux; pop of the head word
// is gated by the pause of the VC it selects.
import main_fifo_pkg::*;

module main_fifo #(
    parameter int DATA_SIZE = MF_DATA_SIZE,
    parameter int ADDR_SIZE = MF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push_main,
    input  logic [DATA_SIZE-1:0] data_in_main,
    input  logic                 pause_vc0,
    input  logic                 pause_vc1,
    input  logic [ADDR_SIZE:0]   thr_almost_full,
    input  logic [ADDR_SIZE:0]   thr_almost_empty,
    output logic                 valid_out_main,
    output logic [DATA_SIZE-1:0] data_out_main,
    output logic                 main_full,
    output logic                 main_empty,
    output logic                 main_almost_full,
    output logic                 main_almost_empty,
    output logic                 main_error
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 valid_q, valid_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 err_q, err_d;

    logic [DATA_SIZE-1:0] head;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 head_blocked;

    main_fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in_main),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // Occupancy and threshold flags straight from the current count.
    assign main_full         = (count_q == DEPTH_C);
    assign main_empty        = (count_q == '0);
    assign main_almost_full  = (count_q >= thr_almost_full);
    assign main_almost_empty = (count_q <= thr_almost_empty);

    // A paused head stalls the whole queue to keep strict order.
    assign head_blocked = vc_paused(vc_sel_e'(head[DATA_SIZE-1]),
                                    pause_vc0, pause_vc1);
    assign push_ok = push_main && !main_full;
    assign pop_ok  = !main_empty && !head_blocked;

    // Next-state for pointers, count, output word and overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
        end
        count_d = count_q
                + (ADDR_SIZE + 1)'(push_ok)
                - (ADDR_SIZE + 1)'(pop_ok);
        valid_d = pop_ok;
        data_d  = pop_ok ? head : '0;
        err_d   = err_q | (push_main & main_full);
    end

    // State registers; reset clears outputs and empties the queue.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign valid_out_main = valid_q;
    assign data_out_main  = data_q;
    assign main_error     = err_q;

endmodule

// File: tb/tb_main_fifo.sv
// Self-checking bench for main_fifo: queue model compared
// every cycle plus directed literal expectations.
module tb_main_fifo;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       push_main;
    logic [5:0] data_in_main;
    logic       pause_vc0;
    logic       pause_vc1;
    logic [2:0] thr_almost_full;
    logic [2:0] thr_almost_empty;
    logic       valid_out_main;
    logic [5:0] data_out_main;
    logic       main_full;
    logic       main_empty;
    logic       main_almost_full;
    logic       main_almost_empty;
    logic       main_error;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [5:0] mq[$];
    logic       m_err;
    logic       m_valid;
    logic [5:0] m_data;

    always #5 clk = ~clk;

    main_fifo dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .push_main         (push_main),
        .data_in_main      (data_in_main),
        .pause_vc0         (pause_vc0),
        .pause_vc1         (pause_vc1),
        .thr_almost_full   (thr_almost_full),
        .thr_almost_empty  (thr_almost_empty),
        .valid_out_main    (valid_out_main),
        .data_out_main     (data_out_main),
        .main_full         (main_full),
        .main_empty        (main_empty),
        .main_almost_full  (main_almost_full),
        .main_almost_empty (main_almost_empty),
        .main_error        (main_error)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Advance the model to the state after the coming rising edge.
    task automatic model_step();
        bit         full;
        bit         pop;
        logic [5:0] hd;
        if (!reset_L) begin
            model_clear();
        end else begin
            full = (mq.size() == 4);
            pop  = 0;
            hd   = '0;
            if (mq.size() != 0) begin
                hd  = mq[0];
                pop = hd[5] ? !pause_vc1 : !pause_vc0;
            end
            if (push_main && full) m_err = 1'b1;
            m_valid = pop;
            m_data  = pop ? hd : 6'h00;
            if (pop) void'(mq.pop_front());
            if (push_main && !full) mq.push_back(data_in_main);
        end
    endtask

    task automatic cyc(input bit pu, input logic [5:0] d,
                       input bit p0, input bit p1);
        push_main    = pu;
        data_in_main = d;
        pause_vc0    = p0;
        pause_vc1    = p1;
        model_step();
        @(negedge clk);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("valid", 8'(valid_out_main), 8'(m_valid));
            chk("data", 8'(data_out_main), 8'(m_data));
            chk("full", 8'(main_full), 8'(mq.size() == 4));
            chk("empty", 8'(main_empty), 8'(mq.size() == 0));
            chk("afull", 8'(main_almost_full),
                8'(mq.size() >= int'(thr_almost_full)));
            chk("aempty", 8'(main_almost_empty),
                8'(mq.size() <= int'(thr_almost_empty)));
            chk("error", 8'(main_error), 8'(m_err));
        end
    end

    initial begin
        logic [5:0] got[$];
        logic [5:0] sent[$];
        logic [5:0] w5[5];
        logic [5:0] d;

        reset_L          = 1'b0;
        push_main        = 1'b0;
        data_in_main     = '0;
        pause_vc0        = 1'b0;
        pause_vc1        = 1'b0;
        thr_almost_full  = 3'd3;
        thr_almost_empty = 3'd1;
        model_clear();
        chk_en = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_valid", 8'(valid_out_main), 8'h0);
        chk("rst_empty", 8'(main_empty), 8'h1);
        chk("rst_aempty", 8'(main_almost_empty), 8'h1);
        chk("rst_afull", 8'(main_almost_full), 8'h0);
        reset_L = 1'b1;

        // Two words, no pause: 2-edge latency, in order.
        cyc(1, 6'h05, 0, 0);
        chk("t1_lat", 8'(valid_out_main), 8'h0);
        cyc(1, 6'h2A, 0, 0);
        chk("t1_v0", 8'(valid_out_main), 8'h1);
        chk("t1_d0", 8'(data_out_main), 8'h05);
        cyc(0, 0, 0, 0);
        chk("t1_v1", 8'(valid_out_main), 8'h1);
        chk("t1_d1", 8'(data_out_main), 8'h2A);
        cyc(0, 0, 0, 0);
        chk("t1_v2", 8'(valid_out_main), 8'h0);
        chk("t1_empty", 8'(main_empty), 8'h1);
        chk("t1_err", 8'(main_error), 8'h0);

        // Overflow with both VCs paused.
        w5[0] = 6'h11; w5[1] = 6'h22; w5[2] = 6'h33;
        w5[3] = 6'h04; w5[4] = 6'h15;
        for (int i = 0; i < 5; i++) cyc(1, w5[i], 1, 1);
        chk("t2_full", 8'(main_full), 8'h1);
        chk("t2_afull", 8'(main_almost_full), 8'h1);
        chk("t2_err", 8'(main_error), 8'h1);
        chk("t2_valid", 8'(valid_out_main), 8'h0);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0);
            if (valid_out_main) got.push_back(data_out_main);
        end
        chk("t2_cnt", 8'(got.size()), 8'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("t2_word", 8'(got[i]), 8'(w5[i]));
            else chk("t2_word", 8'hFF, 8'(w5[i]));
        end
        chk("t2_err_hold", 8'(main_error), 8'h1);
        chk("t2_empty", 8'(main_empty), 8'h1);

        // Paused VC0 head blocks a VC1 word behind it.
        cyc(1, 6'h01, 1, 0);
        cyc(1, 6'h21, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            chk("t3_blk", 8'(valid_out_main), 8'h0);
        end
        cyc(0, 0, 0, 0);
        chk("t3_d0", 8'(data_out_main), 8'h01);
        cyc(0, 0, 0, 0);
        chk("t3_d1", 8'(data_out_main), 8'h21);
        cyc(0, 0, 0, 0);

        // Streaming push+pop from non-empty; pointers wrap.
        sent.delete();
        got.delete();
        cyc(1, 6'h08, 1, 1);
        sent.push_back(6'h08);
        cyc(1, 6'h29, 1, 1);
        sent.push_back(6'h29);
        for (int i = 0; i < 10; i++) begin
            d = 6'(i * 7 + 3);
            cyc(1, d, 0, 0);
            sent.push_back(d);
            if (valid_out_main) got.push_back(data_out_main);
            chk("t4_notempty", 8'(main_empty), 8'h0);
            chk("t4_notfull", 8'(main_full), 8'h0);
        end
        chk("t4_rate", 8'(got.size()), 8'd10);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            if (valid_out_main) got.push_back(data_out_main);
        end
        chk("t4_total", 8'(got.size()), 8'(sent.size()));
        for (int i = 0; i < sent.size(); i++) begin
            if (i < got.size()) chk("t4_seq", 8'(got[i]), 8'(sent[i]));
        end

        // Zero thresholds on an empty FIFO.
        thr_almost_full  = 3'd0;
        thr_almost_empty = 3'd0;
        #1;
        chk("thr_afull0", 8'(main_almost_full), 8'h1);
        chk("thr_aempty0", 8'(main_almost_empty), 8'h1);
        cyc(0, 0, 0, 0);
        thr_almost_full  = 3'd3;
        thr_almost_empty = 3'd1;

        // Async reset mid-stream with 3 words and error set.
        cyc(1, 6'h0A, 1, 1);
        cyc(1, 6'h0B, 1, 1);
        cyc(1, 6'h0C, 1, 1);
        cyc(0, 0, 0, 0);
        #1;
        reset_L = 1'b0;
        model_clear();
        #1;
        chk("t5_valid", 8'(valid_out_main), 8'h0);
        chk("t5_data", 8'(data_out_main), 8'h0);
        chk("t5_empty", 8'(main_empty), 8'h1);
        chk("t5_err", 8'(main_error), 8'h0);
        chk("t5_full", 8'(main_full), 8'h0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        reset_L = 1'b1;
        cyc(1, 6'h3F, 0, 0);
        chk("t5_lat", 8'(valid_out_main), 8'h0);
        cyc(0, 0, 0, 0);
        chk("t5_v", 8'(valid_out_main), 8'h1);
        chk("t5_d", 8'(data_out_main), 8'h3F);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
